// File: rtl/dose_window_monitor.sv
// dose_window_monitor
// Counts accepted analgesic dose requests inside a rolling therapy window.
// It feeds the alarm and clear inputs of the post-operative control FSM.
// An hour timer runs while monitoring is active. After each accepted dose,
// a lockout rejects new requests for a fixed number of cycles. The alarm
// is raised when the per-window dose ceiling is reached.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   enhours    monitoring active (0 = system off)
//   enlev      lever enable; a rising edge is one dose request
//   enchange   bag-change enable; a rising edge acknowledges the alarm
//   alarmon    dose ceiling reached (level)
//   clear      end-of-window pulse, one cycle wide
//   dose_count accepted doses in the current window
//   hour_count completed hours in the current window
//   dose_rej   one-cycle pulse when a request is rejected
module dose_window_monitor #(
   parameter int CYC_PER_HOUR  = 1000,
   parameter int HOURS_PER_DAY = 24,
   parameter int DOSE_MAX      = 8,
   parameter int LOCKOUT_CYC   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enhours,
   input  logic       enlev,
   input  logic       enchange,
   output logic       alarmon,
   output logic       clear,
   output logic [7:0] dose_count,
   output logic [4:0] hour_count,
   output logic       dose_rej
);

   localparam int CW = (CYC_PER_HOUR  > 1) ? $clog2(CYC_PER_HOUR)  : 1;
   localparam int HW = (HOURS_PER_DAY > 1) ? $clog2(HOURS_PER_DAY) : 1;
   localparam int DW = $clog2(DOSE_MAX + 1);
   localparam int LW = $clog2(LOCKOUT_CYC + 1);

   localparam logic [CW-1:0] CYC_LAST   = CW'(CYC_PER_HOUR - 1);
   localparam logic [HW-1:0] HOUR_LAST  = HW'(HOURS_PER_DAY - 1);
   localparam logic [DW-1:0] DOSE_PRE   = DW'(DOSE_MAX - 1);
   localparam logic [LW-1:0] LOCK_INIT  = LW'(LOCKOUT_CYC);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_READY = 2'b01,
      ST_LOCK  = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cyc_r;
   logic [HW-1:0] hour_r;
   logic [DW-1:0] dose_r;
   logic [LW-1:0] lock_r;
   logic          enlev_r;
   logic          enchange_r;
   logic          alarm_r;
   logic          clear_r;
   logic          rej_r;

   logic          lev_rise_s;
   logic          chg_rise_s;
   logic          cyc_end_s;
   logic          wrap_s;

   // Rising-edge and window-end decode from the registered history.
   always_comb begin
      lev_rise_s = enlev & ~enlev_r;
      chg_rise_s = enchange & ~enchange_r;
      cyc_end_s  = (cyc_r == CYC_LAST);
      if (enhours && cyc_end_s && (hour_r == HOUR_LAST)) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
   end

   // One-deep history of the lever and bag-change enables.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         enlev_r    <= 1'b0;
         enchange_r <= 1'b0;
      end else begin
         enlev_r    <= enlev;
         enchange_r <= enchange;
      end
   end

   // Hour timer and end-of-window pulse; runs only while monitoring is active.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_r   <= '0;
         hour_r  <= '0;
         clear_r <= 1'b0;
      end else if (!enhours) begin
         cyc_r   <= '0;
         hour_r  <= '0;
         clear_r <= 1'b0;
      end else if (cyc_end_s) begin
         cyc_r <= '0;
         if (hour_r == HOUR_LAST) begin
            hour_r  <= '0;
            clear_r <= 1'b1;
         end else begin
            hour_r  <= hour_r + HW'(1);
            clear_r <= 1'b0;
         end
      end else begin
         cyc_r   <= cyc_r + CW'(1);
         clear_r <= 1'b0;
      end
   end

   // Dose FSM: the power-off, window-end and acknowledge paths pre-empt lever handling.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_OFF;
         dose_r  <= '0;
         lock_r  <= '0;
         alarm_r <= 1'b0;
         rej_r   <= 1'b0;
      end else begin
         rej_r <= 1'b0;
         if (!enhours) begin
            state_r <= ST_OFF;
            dose_r  <= '0;
            lock_r  <= '0;
            alarm_r <= 1'b0;
         end else if (wrap_s || chg_rise_s) begin
            // A lever edge in this cycle is dropped, not rejected.
            state_r <= ST_READY;
            dose_r  <= '0;
            lock_r  <= '0;
            alarm_r <= 1'b0;
         end else begin
            case (state_r)
               ST_OFF: begin
                  state_r <= ST_READY;
               end
               ST_READY: begin
                  if (lev_rise_s) begin
                     dose_r <= dose_r + DW'(1);
                     lock_r <= LOCK_INIT;
                     if (dose_r == DOSE_PRE) begin
                        state_r <= ST_FULL;
                        alarm_r <= 1'b1;
                     end else begin
                        state_r <= ST_LOCK;
                     end
                  end else begin
                     state_r <= ST_READY;
                  end
               end
               ST_LOCK: begin
                  rej_r <= lev_rise_s;
                  // Reaching zero on this edge re-arms acceptance for the next cycle.
                  if (lock_r <= LW'(1)) begin
                     lock_r  <= '0;
                     state_r <= ST_READY;
                  end else begin
                     lock_r  <= lock_r - LW'(1);
                     state_r <= ST_LOCK;
                  end
               end
               ST_FULL: begin
                  alarm_r <= 1'b1;
                  rej_r   <= lev_rise_s;
               end
               default: begin
                  state_r <= ST_OFF;
                  dose_r  <= '0;
                  lock_r  <= '0;
                  alarm_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign alarmon    = alarm_r;
   assign clear      = clear_r;
   assign dose_rej   = rej_r;
   assign dose_count = 8'(dose_r);
   assign hour_count = 5'(hour_r);

endmodule

// File: tb/tb_dose_window_monitor.sv
// Testbench for dose_window_monitor with a reference model.
// The model works from elapsed active cycles, the index of the last accepted
// dose and the dose count, rather than from a state encoding.
module tb_dose_window_monitor;

   localparam int C = 10;
   localparam int H = 24;
   localparam int D = 3;
   localparam int L = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       enhours;
   logic       enlev;
   logic       enchange;
   logic       alarmon;
   logic       clear;
   logic [7:0] dose_count;
   logic [4:0] hour_count;
   logic       dose_rej;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int m_run;
   int m_dose;
   int m_last;
   int m_edge = 0;
   bit m_off;
   bit m_plv;
   bit m_pch;
   bit m_clr;
   bit m_rej;

   dose_window_monitor #(
      .CYC_PER_HOUR (C),
      .HOURS_PER_DAY(H),
      .DOSE_MAX     (D),
      .LOCKOUT_CYC  (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enhours   (enhours),
      .enlev     (enlev),
      .enchange  (enchange),
      .alarmon   (alarmon),
      .clear     (clear),
      .dose_count(dose_count),
      .hour_count(hour_count),
      .dose_rej  (dose_rej)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_run  = 0;
      m_dose = 0;
      m_last = -1000;
      m_off  = 1'b1;
      m_plv  = 1'b0;
      m_pch  = 1'b0;
      m_clr  = 1'b0;
      m_rej  = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, " hour_count"}, 32'(hour_count), 32'((m_run / C) % H));
      check({ph, " dose_count"}, 32'(dose_count), 32'(m_dose));
      check({ph, " alarmon"},    32'(alarmon),    32'(m_dose == D));
      check({ph, " clear"},      32'(clear),      32'(m_clr));
      check({ph, " dose_rej"},   32'(dose_rej),   32'(m_rej));
   endtask

   task automatic check_zero(input string ph);
      check({ph, " hour_count"}, 32'(hour_count), 32'd0);
      check({ph, " dose_count"}, 32'(dose_count), 32'd0);
      check({ph, " alarmon"},    32'(alarmon),    32'd0);
      check({ph, " clear"},      32'(clear),      32'd0);
      check({ph, " dose_rej"},   32'(dose_rej),   32'd0);
   endtask

   // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
   task automatic step(input bit en, input bit lv, input bit ch, input string ph);
      bit lr;
      bit cr;
      enhours  = en;
      enlev    = lv;
      enchange = ch;
      @(posedge clk);
      m_edge++;
      lr    = lv && !m_plv;
      cr    = ch && !m_pch;
      m_plv = lv;
      m_pch = ch;
      m_clr = 1'b0;
      m_rej = 1'b0;
      if (!en) begin
         m_run  = 0;
         m_dose = 0;
         m_last = -1000;
         m_off  = 1'b1;
      end else begin
         m_run++;
         if (m_run % (C * H) == 0) begin
            m_clr  = 1'b1;
            m_dose = 0;
            m_last = -1000;
            m_off  = 1'b0;
         end else if (m_off) begin
            m_off = 1'b0;
         end else if (cr) begin
            m_dose = 0;
            m_last = -1000;
         end else if (lr) begin
            if (m_dose == D || (m_edge - m_last) <= L) begin
               m_rej = 1'b1;
            end else begin
               m_dose++;
               m_last = m_edge;
            end
         end
      end
      #1;
      check_all(ph);
   endtask

   initial begin
      int guard;
      rst      = 1'b0;
      enhours  = 1'b0;
      enlev    = 1'b0;
      enchange = 1'b0;
      model_reset();

      // Reset held with random inputs: every output stays 0.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         enhours  = 1'($urandom);
         enlev    = 1'($urandom);
         enchange = 1'($urandom);
         #1;
         check_zero("reset");
      end
      @(negedge clk);
      enhours  = 1'b0;
      enlev    = 1'b0;
      enchange = 1'b0;
      rst      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'($urandom), 1'($urandom), "off");
         check("off dose_count", 32'(dose_count), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0, "off");

      // Dose and lockout: accept, reject inside the lockout, accept after it.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "lock");
      step(1'b1, 1'b1, 1'b0, "lock t10");
      check("t10 dose_count", 32'(dose_count), 32'd1);
      step(1'b1, 1'b0, 1'b0, "lock");
      step(1'b1, 1'b1, 1'b0, "lock t12");
      check("t12 dose_rej", 32'(dose_rej), 32'd1);
      check("t12 dose_count", 32'(dose_count), 32'd1);
      step(1'b1, 1'b0, 1'b0, "lock");
      check("t13 dose_rej", 32'(dose_rej), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, "lock");
      step(1'b1, 1'b1, 1'b0, "lock t20");
      check("t20 dose_count", 32'(dose_count), 32'd2);

      // Alarm on the third dose, fourth request rejected.
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "alarm");
      step(1'b1, 1'b1, 1'b0, "alarm third");
      check("third alarmon", 32'(alarmon), 32'd1);
      check("third dose_count", 32'(dose_count), 32'd3);
      step(1'b1, 1'b0, 1'b0, "alarm");
      step(1'b1, 1'b1, 1'b0, "alarm fourth");
      check("fourth dose_rej", 32'(dose_rej), 32'd1);
      check("fourth dose_count", 32'(dose_count), 32'd3);

      // Acknowledge via bag change.
      step(1'b1, 1'b0, 1'b1, "ack");
      check("ack alarmon", 32'(alarmon), 32'd0);
      check("ack dose_count", 32'(dose_count), 32'd0);
      step(1'b1, 1'b0, 1'b0, "ack");

      // Refill to the alarm and run to the window wrap with a lever edge on it.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, "refill");
         for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "refill");
      end
      guard = 0;
      while (((m_run + 1) % (C * H) != 0) && guard < 1000) begin
         step(1'b1, 1'b0, 1'b0, "prewrap");
         guard++;
      end
      check("wrap reached", 32'(guard < 1000), 32'd1);
      check("prewrap alarmon", 32'(alarmon), 32'd1);
      step(1'b1, 1'b1, 1'b0, "wrap");
      check("wrap clear", 32'(clear), 32'd1);
      check("wrap hour_count", 32'(hour_count), 32'd0);
      check("wrap dose_count", 32'(dose_count), 32'd0);
      check("wrap alarmon", 32'(alarmon), 32'd0);
      check("wrap dose_rej", 32'(dose_rej), 32'd0);
      step(1'b1, 1'b0, 1'b0, "postwrap");
      check("postwrap clear", 32'(clear), 32'd0);

      // Power-off mid-lockout, then immediate acceptance after re-enable.
      step(1'b1, 1'b1, 1'b0, "pwr dose");
      step(1'b1, 1'b0, 1'b0, "pwr");
      step(1'b1, 1'b0, 1'b0, "pwr");
      step(1'b0, 1'b0, 1'b0, "pwr off");
      check_zero("pwr off");
      step(1'b1, 1'b0, 1'b0, "pwr on");
      step(1'b1, 1'b1, 1'b0, "pwr redose");
      check("redose dose_count", 32'(dose_count), 32'd1);
      check("redose dose_rej", 32'(dose_rej), 32'd0);

      // Randomised traffic against the model, with one asynchronous reset mid-run.
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) begin
            rst = 1'b0;
            #1;
            check_zero("midreset");
            @(negedge clk);
            rst = 1'b1;
            model_reset();
         end
         step(($urandom_range(0, 399) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 59) == 0), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dose_window_monitor.md
# dose_window_monitor

Upstream feeder of the post-operative control FSM. Counts accepted analgesic dose requests inside a rolling 24-hour therapy window and drives that FSM's `alarmon` and `clear` inputs. It consumes the FSM's `enhours`, `enlev` and `enchange` enables: hours run while monitoring is active, doses are counted on `SOMMA` entries, and a bag change acknowledges the alarm. It enforces a minimum inter-dose lockout and exposes counters for display.

## Interface
- `CYC_PER_HOUR`, 1000: clock cycles per counted hour; must be ≥ 2.
- `HOURS_PER_DAY`, 24: hours per therapy window.
- `DOSE_MAX`, 8: accepted doses per window that raise the alarm; range 1..255.
- `LOCKOUT_CYC`, 50: cycles after an accepted dose during which new requests are rejected; must be ≥ 1.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `enhours`  in  1  monitoring active. 0 means the system is off.
- `enlev`  in  1  lever/dose state enable. A rising edge is one dose request.
- `enchange`  in  1  bag-change enable. A rising edge is the staff acknowledge.
- `alarmon`  out  1  dose ceiling reached. Level output.
- `clear`  out  1  end-of-window pulse, one cycle wide.
- `dose_count`  out  8  accepted doses in the current window.
- `hour_count`  out  5  completed hours in the current window.
- `dose_rej`  out  1  one-cycle pulse when a request is rejected.

## Operation
- Edge detect: `enlev` and `enchange` are registered once. `lev_rise = enlev & ~enlev_q`, and `chg_rise` is formed the same way.
- Hour timer: the cycle counter increments every cycle while `enhours=1`.
  - At `CYC_PER_HOUR-1` the cycle counter wraps to 0 and `hour_count` increments.
  - When `hour_count=HOURS_PER_DAY-1` and the cycle counter wraps:
    - `hour_count` → 0
    - `clear` pulses
    - the window restarts
- State machine has four states: `OFF`, `READY`, `LOCK`, `FULL`.
  - **OFF**: entered when `enhours=0`, from any state.
    - All counters are 0, `alarmon=0`.
    - Goes to `READY` when `enhours=1`.
  - **READY**: on `lev_rise`, `dose_count+1` and the lockout counter is loaded with `LOCKOUT_CYC`.
    - If the new count equals `DOSE_MAX`, go to `FULL`.
    - Otherwise go to `LOCK`.
  - **LOCK**: the lockout counter decrements each cycle.
    - `lev_rise` here gives `dose_rej` and no count change.
    - Goes to `READY` when the counter reaches 0, i.e. `LOCKOUT_CYC` cycles after the accepted edge.
  - **FULL**: `alarmon=1`.
    - `lev_rise` gives `dose_rej` and `dose_count` saturates.
    - Leaves only on window end or `chg_rise`.
- Window end (the `clear` event), from `READY`, `LOCK` or `FULL`:
  - `dose_count` → 0 and the lockout counter → 0.
  - `alarmon` → 0, and the state goes to `READY`.
- `chg_rise` (bag change):
  - `dose_count` → 0, the lockout counter → 0, `alarmon` → 0, and the state goes to `READY`.
  - The hour timer is unaffected.
- Priority in one cycle, highest first: `enhours=0`, then window end, then `chg_rise`, then `lev_rise`.
  - A `lev_rise` coinciding with window end or `chg_rise` is dropped. It is neither counted nor rejected.
- Arithmetic: every counter width is sized `$clog2` of its parameter.
  - `dose_count` never exceeds `DOSE_MAX`.
  - `hour_count` never exceeds `HOURS_PER_DAY-1`.

## Timing
- Reset (`rst=0`) forces every output to 0 immediately, including `clear`, `alarmon` and `dose_rej`. State → `OFF`, edge registers → 0.
  - The first cycle after reset release cannot produce a rising edge unless the input is 1 then.
- All outputs are registered and there is no combinational input→output path.
- `enlev` going 0→1 in cycle N:
  - `dose_count` updates at edge N+1 and `dose_rej` is high in cycle N+1.
  - `alarmon` rises in cycle N+1 on the dose that reaches `DOSE_MAX`.
- `clear` is high exactly one cycle: the cycle after the counters held (`HOURS_PER_DAY-1`, `CYC_PER_HOUR-1`).
  - `alarmon=0` and `dose_count=0` in that same cycle.
- `enhours` falling: every counter and output is 0 from the next cycle.
- `enhours` re-rising: the window starts at cycle 0 and hour 0.
- Reset mid-lockout or mid-window: state is lost and there is no resume.

## Test plan
All scenarios use `CYC_PER_HOUR=10`, `HOURS_PER_DAY=24`, `DOSE_MAX=3`, `LOCKOUT_CYC=5`.
- **Reset/off:** hold `rst=0` with random inputs, then release with `enhours=0` for 20 cycles → all outputs 0 throughout.
- **Dose and lockout:** `enhours=1`, `enlev` edges at t=10, t=12 and t=20.
  - t=10 accepted: `dose_count=1`.
  - t=12 rejected: one-cycle `dose_rej`, count stays 1.
  - t=20 accepted: `dose_count=2`.
- **Alarm:** three accepted doses spaced 10 cycles apart → `alarmon=1` the cycle after the third edge, `dose_count=3`.
  - A fourth edge gives `dose_rej` and the count stays 3.
- **Acknowledge:** from the alarm case, pulse `enchange` → next cycle `alarmon=0` and `dose_count=0`, with `hour_count` unchanged.
- **Window wrap:** run 240 cycles with `alarmon=1` → a single `clear` pulse at cycle 240.
  - In that cycle `hour_count=0`, `dose_count=0` and `alarmon=0`.
  - An `enlev` edge in the same cycle is dropped: no count and no `dose_rej`.
- **Power-off mid-lockout:** drop `enhours` 2 cycles after an accepted dose → all outputs 0 next cycle.
  - Re-enable, then give an `enlev` edge 1 cycle later → it is accepted, since no stale lockout remains.
